div_clk_ctrl: RTL
=================

DIV_CLK_CTRL -- requirements
Module: div_clk_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: width of divide-ratio and period-counter fields.
REQ-002 Parameter DEF_DIV, default 6: divide ratio loaded after reset; SHALL be >= 2.
REQ-003 Parameter HOLD_CYC, default 2: cycles the divided clock is gated off around a ratio change; SHALL be >= 1.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_a_valid  in  1  requester A offers a new ratio.
REQ-007 req_a_div  in  CNT_W  requester A ratio.
REQ-008 req_a_ready  out  1  requester A accepted when valid & ready.
REQ-009 req_b_valid, req_b_div, req_b_ready  same as A, for requester B.
REQ-010 div_num_o  out  CNT_W  ratio driven to the runtime divider.
REQ-011 div_load_o  out  1  one-cycle pulse; divider clears both edge counters.
REQ-012 clk_en_o  out  1  gate for the divided clock output.
REQ-013 period_o  out  1  pulse on the last clk cycle of each divided period.
REQ-014 busy_o  out  1  high in any state except RUN.
REQ-015 err_o  out  1  one-cycle pulse: accepted ratio < 2 was rejected.

Function
REQ-016 FSM states SHALL be RUN, DRAIN, HOLD, LOAD; all outputs registered.
REQ-017 Period counter SHALL count 0..div_num_o-1 and wrap in RUN and DRAIN; held at 0 in HOLD and LOAD; period_o = 1 when count == div_num_o-1 in RUN/DRAIN.
REQ-018 Readies SHALL be asserted only in RUN, at most one per cycle.
REQ-019 Arbitration SHALL be round-robin: single valid is granted; both valid grants the requester not granted last; pointer updates only on acceptance.
REQ-020 Accepted ratio < 2: state stays RUN, err_o pulses next cycle, div_num_o unchanged.
REQ-021 Accepted ratio == div_num_o: state stays RUN, no gating, no load pulse.
REQ-022 Other accepted ratio: latched to pending register; RUN -> DRAIN next cycle.
REQ-023 DRAIN SHALL keep clk_en_o = 1 and exit to HOLD after the cycle where count == div_num_o-1 (acceptance on a boundary cycle waits one full further period).
REQ-024 HOLD SHALL last exactly HOLD_CYC cycles with clk_en_o = 0, then -> LOAD.
REQ-025 LOAD SHALL last one cycle: div_num_o = pending, div_load_o = 1, clk_en_o = 0; then -> RUN with clk_en_o = 1 and count = 0.
REQ-026 Requests arriving while busy_o = 1 SHALL see ready = 0 and are held by the requester, not dropped.
REQ-027 Ratio comparisons unsigned, CNT_W bits; ratio 0 and 1 both count as < 2.

Reset
REQ-028 rst SHALL enter HOLD with: hold counter 0, period counter 0, pending = DEF_DIV, div_num_o = DEF_DIV, clk_en_o = 0, div_load_o = 0, readies 0, period_o 0, err_o 0, busy_o 1, RR pointer favouring A.
REQ-029 rst mid-operation (any state) SHALL discard the pending ratio and behave as REQ-028; first load after reset uses DEF_DIV.

Structure
REQ-030 Shared package SHALL hold the FSM state enum and the minimum legal ratio constant (2).
REQ-031 Round-robin two-way arbiter SHALL be a sub-module rr_arb2 (valid_a/valid_b in, grant_a/grant_b out, pointer update on accept).

Verification
REQ-032 Reset release -> busy 1, clk_en 0 for 2 cycles, div_load pulse with div_num_o = 6 on cycle 3, RUN and clk_en 1 on cycle 4.
REQ-033 A requests 4 at count 2 of 6 -> DRAIN until count 5, HOLD 2 cycles, LOAD with div_num_o = 4, period_o then every 4 cycles.
REQ-034 A and B valid together for three grants (ratios 3/5) -> grants A, B, A in order, each after the preceding change completes.
REQ-035 B requests 1 -> accepted, err_o pulse next cycle, div_num_o stays 6, clk_en never drops.
REQ-036 A requests 6 while div_num_o = 6 -> accepted, no load pulse, busy_o stays 0.
REQ-037 rst asserted during DRAIN with pending 3 -> reset sequence reloads 6; ratio 3 never appears on div_num_o.

Source files
------------

// File: rtl/div_clk_ctrl_pkg.sv
// Shared types for the divided-clock ratio controller.
// Holds the FSM state encoding and the minimum legal divide ratio.
package div_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HOLD,
    S_LOAD
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/div_clk_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst, en (grant enable), valid_a/valid_b in, grant_a/grant_b out.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid_a,
  input  logic valid_b,
  output logic grant_a,
  output logic grant_b
);

  // prio_b = 1 means B wins a tie (A was granted last)
  logic prio_b;

  assign grant_a = en & valid_a & (~valid_b | ~prio_b);
  assign grant_b = en & valid_b & (~valid_a | prio_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (grant_a | grant_b) begin
      prio_b <= grant_a;
    end
  end

endmodule

// File: rtl/div_clk_ctrl.sv
// Glitch-safe divide-ratio controller: drains the current period, gates the
// divided clock, loads the new ratio. Ports: two valid/ready ratio requesters,
// div_num_o/div_load_o to the divider, clk_en_o, period_o, busy_o, err_o.
module div_clk_ctrl
  import div_clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DEF_DIV  = 6,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a_valid,
  input  logic [CNT_W-1:0] req_a_div,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [CNT_W-1:0] req_b_div,
  output logic             req_b_ready,
  output logic [CNT_W-1:0] div_num_o,
  output logic             div_load_o,
  output logic             clk_en_o,
  output logic             period_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pending;
  logic [HW-1:0]    hold_cnt;
  logic             cnt_last;
  logic             period_nxt;
  logic             arb_en;
  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic [CNT_W-1:0] acc_div;

  assign arb_en = (state == S_RUN) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .valid_a (req_a_valid),
    .valid_b (req_b_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;
  assign accept      = grant_a | grant_b;
  assign acc_div     = grant_b ? req_b_div : req_a_div;

  assign cnt_last   = (cnt == div_num_o - 1'b1);
  assign cnt_nxt    = cnt_last ? '0 : cnt + 1'b1;
  // period_o is registered, so it is derived from the next count
  assign period_nxt = (cnt_nxt == div_num_o - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOLD;
      hold_cnt   <= '0;
      cnt        <= '0;
      pending    <= CNT_W'(DEF_DIV);
      div_num_o  <= CNT_W'(DEF_DIV);
      clk_en_o   <= 1'b0;
      div_load_o <= 1'b0;
      period_o   <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b1;
    end else begin
      div_load_o <= 1'b0;
      err_o      <= 1'b0;
      unique case (state)
        S_RUN: begin
          cnt      <= cnt_nxt;
          period_o <= period_nxt;
          if (accept) begin
            if (acc_div < CNT_W'(MIN_DIV)) begin
              err_o <= 1'b1;
            end else if (acc_div != div_num_o) begin
              pending <= acc_div;
              state   <= S_DRAIN;
              busy_o  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_last) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            cnt      <= '0;
            clk_en_o <= 1'b0;
            period_o <= 1'b0;
          end else begin
            cnt      <= cnt_nxt;
            period_o <= period_nxt;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state      <= S_LOAD;
            div_num_o  <= pending;
            div_load_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          state    <= S_RUN;
          clk_en_o <= 1'b1;
          busy_o   <= 1'b0;
          cnt      <= '0;
          period_o <= 1'b0;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
